// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : single-port data memory controller, byte/half/word access with
//             fault detection, optional wait states and response backpressure.
// Revision  : 1.0
// ============================================================================
module dmem_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [1:0]  SZ_R = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          w_misalign;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic          w_unused;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      SZ_H:    w_misalign = addr[0];
      SZ_W:    w_misalign = |addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_fault = (req_size == SZ_R) || w_misalign ||
                   ({2'b00, addr[31:2]} >= 32'(DEPTH));

  assign w_idx    = addr_q[AW+1:2];
  assign w_unused = &{1'b0, addr_q[31:AW+2]};

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wlane = wdata_q;
    case (size_q)
      SZ_B: begin
        w_be    = 4'b0001 << addr_q[1:0];
        w_wlane = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {addr_q[1], 1'b0};
        w_wlane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_word  = mem[w_idx];
  assign w_shift = w_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (size_q)
      SZ_B:    w_load = {{24{~uns_q & w_shift[7]}},  w_shift[7:0]};
      SZ_H:    w_load = {{16{~uns_q & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  // Storage has no reset; an asserted rst_n has already forced the FSM out of ACCESS.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            if (w_fault) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
              state_q <= S_RESP;
            end else if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          err_q   <= 1'b0;
          rdata_q <= we_q ? 32'd0 : w_load;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire
